// File: rtl/adder_chk_pkg.sv
// Shared types and default sizing for the adder vector checker.
// Holds the run FSM state encoding and the stored vector record layout.
package adder_chk_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_SETTLE = 1;
  localparam int DEF_ERR_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    WAIT,
    DONE
  } state_t;

  // Stored vector record at default width; memory packs fields as {a, b, exp}.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
    logic [DEF_WIDTH:0]   exp;
  } vec_t;

endpackage

// File: rtl/adder_vec_mem.sv
// Vector register file: synchronous write, asynchronous read.
// Contents are intentionally not reset so vectors survive a run abort.
module adder_vec_mem
  import adder_chk_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [3*WIDTH:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [3*WIDTH:0]  rd_data_o
);

  logic [3*WIDTH:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/adder_vec_checker.sv
// Self-test sequencer around an external WIDTH-bit adder: applies stored vectors,
// counts sum mismatches and reports a verdict. Optional macro: FIRST_FAIL_CAPTURE_EN.
module adder_vec_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SETTLE = DEF_SETTLE,
  parameter int ERR_W  = DEF_ERR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_a,
  input  logic [WIDTH-1:0]  wr_b,
  input  logic [WIDTH:0]    wr_exp,
  input  logic [ADDR_W:0]   num_vec,
  input  logic              start,
  output logic [WIDTH-1:0]  a_o,
  output logic [WIDTH-1:0]  b_o,
  input  logic [WIDTH:0]    y_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] vec_idx
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic              ff_valid,
  output logic [ADDR_W-1:0] ff_idx,
  output logic [WIDTH:0]    ff_y,
  output logic [WIDTH:0]    ff_exp
`endif
);

  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [ADDR_W:0]  DEPTH_N  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [ADDR_W:0]    n_q, n_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]   settle_q, settle_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               pass_q, pass_d;
  logic [ADDR_W:0]    n_clip;

`ifdef FIRST_FAIL_CAPTURE_EN
  logic               ff_valid_q, ff_valid_d;
  logic [ADDR_W-1:0]  ff_idx_q, ff_idx_d;
  logic [WIDTH:0]     ff_y_q, ff_y_d;
  logic [WIDTH:0]     ff_exp_q, ff_exp_d;
`endif

  logic               wr_ok;
  logic [3*WIDTH:0]   rd_data;
  logic [WIDTH-1:0]   rd_a;
  logic [WIDTH-1:0]   rd_b;
  logic [WIDTH:0]     rd_exp;

  // Vectors may only change while no run is reading them.
  assign wr_ok = wr_en && ((state_q == IDLE) || (state_q == DONE)) &&
                 ({1'b0, wr_addr} < DEPTH_N);

  adder_vec_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk      (clk),
    .wr_en_i  (wr_ok),
    .wr_addr_i(wr_addr),
    .wr_data_i({wr_a, wr_b, wr_exp}),
    .rd_addr_i(idx_q),
    .rd_data_o(rd_data)
  );

  assign rd_a   = rd_data[3*WIDTH:2*WIDTH+1];
  assign rd_b   = rd_data[2*WIDTH:WIDTH+1];
  assign rd_exp = rd_data[WIDTH:0];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    err_d    = err_q;
    pass_d   = pass_q;
    n_clip   = '0;
`ifdef FIRST_FAIL_CAPTURE_EN
    ff_valid_d = ff_valid_q;
    ff_idx_d   = ff_idx_q;
    ff_y_d     = ff_y_q;
    ff_exp_d   = ff_exp_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          n_clip = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
          n_d    = n_clip;
          err_d  = '0;
          pass_d = 1'b0;
          idx_d  = '0;
`ifdef FIRST_FAIL_CAPTURE_EN
          ff_valid_d = 1'b0;
          ff_idx_d   = '0;
          ff_y_d     = '0;
          ff_exp_d   = '0;
`endif
          // An empty run reports an immediate clean verdict.
          if (n_clip == '0) begin
            pass_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = APPLY;
          end
        end
      end

      APPLY: begin
        a_d      = rd_a;
        b_d      = rd_b;
        settle_d = SETTLE_C;
        state_d  = WAIT;
      end

      WAIT: begin
        settle_d = settle_q - 1'b1;
        if (settle_q <= CNT_W'(1)) begin
          if (y_i != rd_exp) begin
            if (err_q != '1) begin
              err_d = err_q + 1'b1;
            end
`ifdef FIRST_FAIL_CAPTURE_EN
            if (!ff_valid_q) begin
              ff_valid_d = 1'b1;
              ff_idx_d   = idx_q;
              ff_y_d     = y_i;
              ff_exp_d   = rd_exp;
            end
`endif
          end
          if ({1'b0, idx_q} == n_q - 1'b1) begin
            pass_d  = (err_d == '0);
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = APPLY;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      idx_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      pass_q   <= 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
      ff_valid_q <= 1'b0;
      ff_idx_q   <= '0;
      ff_y_q     <= '0;
      ff_exp_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
`ifdef FIRST_FAIL_CAPTURE_EN
      ff_valid_q <= ff_valid_d;
      ff_idx_q   <= ff_idx_d;
      ff_y_q     <= ff_y_d;
      ff_exp_q   <= ff_exp_d;
`endif
    end
  end

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign busy    = (state_q == APPLY) || (state_q == WAIT);
  assign done    = (state_q == DONE);
  assign pass    = pass_q;
  assign err_cnt = err_q;
  assign vec_idx = idx_q;

`ifdef FIRST_FAIL_CAPTURE_EN
  assign ff_valid = ff_valid_q;
  assign ff_idx   = ff_idx_q;
  assign ff_y     = ff_y_q;
  assign ff_exp   = ff_exp_q;
`endif

endmodule

// File: tb/tb_adder_vec_checker.sv
// Bench for adder_vec_checker: carry table, directed run scenarios and random runs
// checked against a run-level model. Honors FIRST_FAIL_CAPTURE_EN when defined.
module tb_adder_vec_checker;
  import adder_chk_pkg::*;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int SETTLE = 1;
  localparam int ERR_W  = 8;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_a;
  logic [WIDTH-1:0]  wr_b;
  logic [WIDTH:0]    wr_exp;
  logic [ADDR_W:0]   num_vec;
  logic              start;
  logic [WIDTH-1:0]  a_o;
  logic [WIDTH-1:0]  b_o;
  logic [WIDTH:0]    y_i;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_cnt;
  logic [ADDR_W-1:0] vec_idx;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic              ff_valid;
  logic [ADDR_W-1:0] ff_idx;
  logic [WIDTH:0]    ff_y;
  logic [WIDTH:0]    ff_exp;
`endif

  logic [WIDTH:0] adderXor;

  // External adder, with an optional bit flip to emulate a faulty unit.
  assign y_i = ({1'b0, a_o} + {1'b0, b_o}) ^ adderXor;

  adder_vec_checker #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .SETTLE(SETTLE),
    .ERR_W (ERR_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_a    (wr_a),
    .wr_b    (wr_b),
    .wr_exp  (wr_exp),
    .num_vec (num_vec),
    .start   (start),
    .a_o     (a_o),
    .b_o     (b_o),
    .y_i     (y_i),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err_cnt (err_cnt),
    .vec_idx (vec_idx)
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    .ff_valid(ff_valid),
    .ff_idx  (ff_idx),
    .ff_y    (ff_y),
    .ff_exp  (ff_exp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun;
  int testsFailed;
  vec_t refMem [DEPTH];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] e;
    logic       expPass;
    int         expErr;
  } carryCase_t;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic writeVec(input int addr, input logic [7:0] a, input logic [7:0] b,
                          input logic [8:0] e);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(addr);
    wr_a    = a;
    wr_b    = b;
    wr_exp  = e;
    @(negedge clk);
    wr_en = 1'b0;
    if (addr < DEPTH) begin
      refMem[addr].a   = a;
      refMem[addr].b   = b;
      refMem[addr].exp = e;
    end
  endtask

  // Run-level model: which stored vectors the adder disagrees with, and when done lands.
  task automatic modelRun(input int numVec, output int expCycles, output int expErr,
                          output int expPass, output int expIdx, output int ffIdx,
                          output int ffY, output int ffExp);
    int n;
    int errs;
    int sum;
    n = (numVec > DEPTH) ? DEPTH : numVec;
    errs = 0;
    ffIdx = 0; ffY = 0; ffExp = 0;
    for (int i = 0; i < n; i++) begin
      sum = (int'(refMem[i].a) + int'(refMem[i].b)) ^ int'(adderXor);
      if (sum != int'(refMem[i].exp)) begin
        if (errs == 0) begin
          ffIdx = i;
          ffY   = sum;
          ffExp = int'(refMem[i].exp);
        end
        errs++;
      end
    end
    expErr    = (errs > 255) ? 255 : errs;
    expPass   = (errs == 0) ? 1 : 0;
    expCycles = (SETTLE + 1) * n + 1;
    expIdx    = (n > 0) ? n - 1 : 0;
  endtask

  // Starts a run and counts cycles until done; optionally pokes start/wr_en mid-run.
  task automatic applyStimulus(input int numVec, input int injectAt, output int cycles,
                               output logic busySeen);
    num_vec = (ADDR_W + 1)'(numVec);
    start   = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    cycles   = 1;
    busySeen = busy;
    while (!done && cycles < 200) begin
      if (cycles == injectAt) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_a    = 8'hAA;
        wr_b    = 8'h55;
        wr_exp  = 9'h000;
      end
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      cycles++;
    end
    if (!done) checkOutput("done timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic checkRun(input string tag, input int numVec, input int injectAt);
    int expCycles, expErr, expPass, expIdx, ffIdxE, ffYE, ffExpE;
    int cycles;
    logic busySeen;
    modelRun(numVec, expCycles, expErr, expPass, expIdx, ffIdxE, ffYE, ffExpE);
    applyStimulus(numVec, injectAt, cycles, busySeen);
    checkOutput({tag, " done latency"}, cycles, expCycles);
    checkOutput({tag, " busy early"}, {31'b0, busySeen}, (numVec > 0) ? 32'd1 : 32'd0);
    checkOutput({tag, " busy at done"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, " pass"}, {31'b0, pass}, expPass);
    checkOutput({tag, " err_cnt"}, {24'b0, err_cnt}, expErr);
    checkOutput({tag, " vec_idx"}, {27'b0, vec_idx}, expIdx);
`ifdef FIRST_FAIL_CAPTURE_EN
    checkOutput({tag, " ff_valid"}, {31'b0, ff_valid}, (expErr > 0) ? 32'd1 : 32'd0);
    if (expErr > 0) begin
      checkOutput({tag, " ff_idx"}, {27'b0, ff_idx}, ffIdxE);
      checkOutput({tag, " ff_y"}, {23'b0, ff_y}, ffYE);
      checkOutput({tag, " ff_exp"}, {23'b0, ff_exp}, ffExpE);
    end
`endif
    @(negedge clk);
    checkOutput({tag, " done pulse width"}, {31'b0, done}, 32'd0);
    checkOutput({tag, " pass held"}, {31'b0, pass}, expPass);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " busy"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, " done"}, {31'b0, done}, 32'd0);
    checkOutput({tag, " pass"}, {31'b0, pass}, 32'd0);
    checkOutput({tag, " err_cnt"}, {24'b0, err_cnt}, 32'd0);
    checkOutput({tag, " vec_idx"}, {27'b0, vec_idx}, 32'd0);
    checkOutput({tag, " a_o"}, {24'b0, a_o}, 32'd0);
    checkOutput({tag, " b_o"}, {24'b0, b_o}, 32'd0);
`ifdef FIRST_FAIL_CAPTURE_EN
    checkOutput({tag, " ff_valid"}, {31'b0, ff_valid}, 32'd0);
    checkOutput({tag, " ff_idx"}, {27'b0, ff_idx}, 32'd0);
`endif
  endtask

  initial begin
    carryCase_t carryTable [8];
    int cycles;
    int waitCount;
    int donePulses;
    int n;
    int inj;
    logic busySeen;
    logic [8:0] e;
    logic [7:0] ra, rb;

    testsRun    = 0;
    testsFailed = 0;
    adderXor    = '0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_a    = '0;
    wr_b    = '0;
    wr_exp  = '0;
    num_vec = '0;
    start   = 1'b0;

    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;
    @(negedge clk);

    carryTable[0] = '{8'hFF, 8'h01, 9'h100, 1'b1, 0};
    carryTable[1] = '{8'hFF, 8'h01, 9'h000, 1'b0, 1};
    carryTable[2] = '{8'h80, 8'h80, 9'h100, 1'b1, 0};
    carryTable[3] = '{8'h80, 8'h80, 9'h000, 1'b0, 1};
    carryTable[4] = '{8'h00, 8'h00, 9'h000, 1'b1, 0};
    carryTable[5] = '{8'h7F, 8'h01, 9'h080, 1'b1, 0};
    carryTable[6] = '{8'hFF, 8'hFF, 9'h1FE, 1'b1, 0};
    carryTable[7] = '{8'hFF, 8'hFF, 9'h0FE, 1'b0, 1};
    for (int i = 0; i < 8; i++) begin
      writeVec(0, carryTable[i].a, carryTable[i].b, carryTable[i].e);
      applyStimulus(1, -1, cycles, busySeen);
      checkOutput($sformatf("carry[%0d] latency", i), cycles, 32'd3);
      checkOutput($sformatf("carry[%0d] pass", i), {31'b0, pass}, {31'b0, carryTable[i].expPass});
      checkOutput($sformatf("carry[%0d] err_cnt", i), {24'b0, err_cnt}, carryTable[i].expErr);
      @(negedge clk);
    end

    for (int i = 0; i < 25; i++) writeVec(i, 8'(i), 8'(i), 9'(2 * i));
    checkRun("load25", 25, -1);

    writeVec(3, 8'd3, 8'd3, 9'd7);
    writeVec(17, 8'd17, 8'd17, 9'd35);
    checkRun("corrupt", 25, -1);
    checkOutput("corrupt err_cnt literal", {24'b0, err_cnt}, 32'd2);
`ifdef FIRST_FAIL_CAPTURE_EN
    checkOutput("corrupt ff_idx literal", {27'b0, ff_idx}, 32'd3);
    checkOutput("corrupt ff_y literal", {23'b0, ff_y}, 32'd6);
    checkOutput("corrupt ff_exp literal", {23'b0, ff_exp}, 32'd7);
`endif

    checkRun("n0", 0, -1);

    for (int i = 25; i < 31; i++) writeVec(i, 8'(i), 8'(i), 9'(2 * i));
    writeVec(31, 8'd31, 8'd31, 9'd63);
    checkRun("n40", 40, -1);

    checkRun("inject", 25, 7);
    checkRun("after inject", 25, -1);

    adderXor = 9'h100;
    checkRun("adder carry fault", 10, -1);
    adderXor = '0;

    writeVec(3, 8'd3, 8'd3, 9'd6);
    writeVec(17, 8'd17, 8'd17, 9'd34);
    writeVec(31, 8'd31, 8'd31, 9'd62);

    // Abort a run at vector 10 with a one-cycle reset.
    num_vec = 6'd25;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitCount  = 0;
    donePulses = 0;
    while (vec_idx != 5'd10 && waitCount < 100) begin
      @(negedge clk);
      waitCount++;
      if (done) donePulses++;
    end
    checkOutput("reach vec 10", {27'b0, vec_idx}, 32'd10);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkResetState("midrun reset");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) donePulses++;
    end
    checkOutput("midrun no done", donePulses, 32'd0);
    checkRun("post reset", 25, -1);

    for (int iter = 0; iter < 12; iter++) begin
      for (int i = 0; i < DEPTH; i++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        e  = ({1'b0, ra} + {1'b0, rb});
        if ($urandom_range(0, 3) == 0) e = 9'($urandom);
        writeVec(i, ra, rb, e);
      end
      n = $urandom_range(0, 40);
      adderXor = ($urandom_range(0, 3) == 0) ? 9'(1 << $urandom_range(0, 8)) : 9'h000;
      inj = -1;
      if (n > 0 && $urandom_range(0, 1) == 1)
        inj = $urandom_range(1, 2 * ((n > DEPTH) ? DEPTH : n));
      checkRun($sformatf("random[%0d]", iter), n, inj);
      adderXor = '0;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
